uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two byte producers: requester 0 is the CPU I/O port and requester 1 is the debug/monitor port. Bytes are accepted over a valid/ready handshake and arbitrated round-robin, with an optional per-requester lock that keeps multi-byte packets contiguous. The block sequences the transmitter's start/data/busy interface: one start pulse per byte, then it waits for busy to rise and fall. A missing busy acknowledge is flagged as an error.

---
 rtl/uart_tx_arbiter_if.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the two byte producers, the UART transmitter and the arbiter status outputs.
// The arbiter binds to master, the environment (producers plus transmitter) binds to slave.
interface uart_tx_arbiter_if;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_lock;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_lock;
   logic       req1_ready;
   logic [7:0] uart_data;
   logic       uart_start;
   logic       uart_busy;
   logic       grant_id;
   logic       active;
   logic       locked;
   logic       err_pulse;

   modport master (
      input  req0_valid, req0_data, req0_lock,
      output req0_ready,
      input  req1_valid, req1_data, req1_lock,
      output req1_ready,
      output uart_data, uart_start,
      input  uart_busy,
      output grant_id, active, locked, err_pulse
   );

   modport slave (
      output req0_valid, req0_data, req0_lock,
      input  req0_ready,
      output req1_valid, req1_data, req1_lock,
      input  req1_ready,
      input  uart_data, uart_start,
      output uart_busy,
      input  grant_id, active, locked, err_pulse
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin/lockable arbiter feeding one UART transmitter; accept to uart_start is 1 cycle.
// Backpressure: readyN pulses only in IDLE with uart_busy low, so producers hold valid until then.
module uart_tx_arbiter #(
   parameter int unsigned ACK_TIMEOUT  = 4,
   parameter int unsigned LOCK_TIMEOUT = 1024,
   parameter int unsigned CW           = 16
) (
   input  logic              clk,
   input  logic              rst,
   uart_tx_arbiter_if.master arb_io
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } state_e;

   localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic          rr_last_q;
   logic          locked_q;
   logic          owner_q;
   logic [7:0]    uart_data_q;
   logic          uart_start_q;
   logic          grant_id_q;
   logic          err_pulse_q;

   logic          own_valid;
   logic          own_lock;
   logic          gnt_vld;
   logic          gnt_id;
   logic          gnt_lock;
   logic [7:0]    gnt_dat;
   logic          lock_wait;
   logic          lock_clr;

   assign own_valid = owner_q ? arb_io.req1_valid : arb_io.req0_valid;
   assign own_lock  = owner_q ? arb_io.req1_lock  : arb_io.req0_lock;

   // Grant is only ever decided in IDLE with an idle transmitter; reset masks it so no byte is lost.
   always_comb begin
      gnt_vld   = 1'b0;
      gnt_id    = 1'b0;
      lock_wait = 1'b0;
      lock_clr  = 1'b0;
      if (!rst && (state_q == IDLE) && !arb_io.uart_busy) begin
         if (locked_q && own_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = owner_q;
         end else if (locked_q && own_lock) begin
            lock_wait = 1'b1;
         end else begin
            lock_clr = locked_q;
            if (arb_io.req0_valid && arb_io.req1_valid) begin
               gnt_vld = 1'b1;
               gnt_id  = ~rr_last_q;
            end else if (arb_io.req0_valid) begin
               gnt_vld = 1'b1;
               gnt_id  = 1'b0;
            end else if (arb_io.req1_valid) begin
               gnt_vld = 1'b1;
               gnt_id  = 1'b1;
            end
         end
      end
   end

   assign gnt_dat  = gnt_id ? arb_io.req1_data : arb_io.req0_data;
   assign gnt_lock = gnt_id ? arb_io.req1_lock : arb_io.req0_lock;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         rr_last_q    <= 1'b1;
         locked_q     <= 1'b0;
         owner_q      <= 1'b0;
         uart_data_q  <= 8'h00;
         uart_start_q <= 1'b0;
         grant_id_q   <= 1'b0;
         err_pulse_q  <= 1'b0;
      end else begin
         uart_start_q <= 1'b0;
         err_pulse_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (gnt_vld) begin
                  uart_data_q  <= gnt_dat;
                  grant_id_q   <= gnt_id;
                  rr_last_q    <= gnt_id;
                  owner_q      <= gnt_id;
                  locked_q     <= gnt_lock;
                  uart_start_q <= 1'b1;
                  cnt_q        <= '0;
                  state_q      <= START;
               end else if (lock_wait) begin
                  if (cnt_q == LOCK_LAST) begin
                     locked_q <= 1'b0;
                     cnt_q    <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else begin
                  locked_q <= locked_q & ~lock_clr;
                  cnt_q    <= '0;
               end
            end
            START: begin
               cnt_q   <= '0;
               state_q <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (arb_io.uart_busy) begin
                  state_q <= WAIT_DONE;
               end else if (cnt_q == ACK_LAST) begin
                  // Byte is dropped, not retried; the lock survives so the owner can resend.
                  err_pulse_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!arb_io.uart_busy) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign arb_io.req0_ready = gnt_vld & ~gnt_id;
   assign arb_io.req1_ready = gnt_vld & gnt_id;
   assign arb_io.uart_data  = uart_data_q;
   assign arb_io.uart_start = uart_start_q;
   assign arb_io.grant_id   = grant_id_q;
   assign arb_io.active     = (state_q != IDLE);
   assign arb_io.locked     = locked_q;
   assign arb_io.err_pulse  = err_pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter model, byte monitor and a queue-level arbitration model.
module tb_uart_tx_arbiter;
   localparam int AT    = 4;
   localparam int LT    = 20;
   localparam int FRAME = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if bus_if ();

   uart_tx_arbiter #(.ACK_TIMEOUT(AT), .LOCK_TIMEOUT(LT), .CW(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_io (bus_if)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Transmitter model: busy rises the cycle after the start pulse and stays high FRAME cycles.
   bit model_busy = 1'b0;
   bit pend       = 1'b0;
   int fcnt       = 0;
   bit tx_ack_en  = 1'b1;
   bit force_busy = 1'b0;
   assign bus_if.uart_busy = tx_ack_en ? model_busy : force_busy;

   always @(posedge clk) begin
      #1;
      if (fcnt > 0) begin
         fcnt--;
         if (fcnt == 0) model_busy = 1'b0;
      end
      if (pend) begin
         model_busy = 1'b1;
         fcnt       = FRAME;
         pend       = 1'b0;
      end
      if (bus_if.uart_start) pend = 1'b1;
   end

   bit [8:0] tx_log[$];
   int       err_cnt = 0;
   always @(negedge clk) begin
      if (bus_if.uart_start) tx_log.push_back({bus_if.grant_id, bus_if.uart_data});
      if (bus_if.err_pulse) err_cnt++;
   end

   // Producer queues: bit 8 is the lock flag, bits 7:0 the byte.
   bit [8:0] q0[$];
   bit [8:0] q1[$];
   bit [8:0] src0[$];
   bit [8:0] src1[$];
   bit [8:0] exp_q[$];

   // Expected transmit order from the arbitration rules alone.
   task automatic build_expected();
      int i0 = 0;
      int i1 = 0;
      int own = -1;
      bit last = 1'b1;
      bit h0, h1;
      bit pick;
      bit [8:0] b;
      exp_q.delete();
      while (i0 < src0.size() || i1 < src1.size()) begin
         h0 = (i0 < src0.size());
         h1 = (i1 < src1.size());
         if (own == 0 && h0) pick = 1'b0;
         else if (own == 1 && h1) pick = 1'b1;
         else if (h0 && h1) pick = ~last;
         else pick = h1;
         if (pick) begin b = src1[i1]; i1++; end
         else begin b = src0[i0]; i0++; end
         exp_q.push_back({pick, b[7:0]});
         own  = b[8] ? int'(pick) : -1;
         last = pick;
      end
   endtask

   task automatic drive_reqs();
      bit [8:0] t;
      bus_if.req0_valid = (q0.size() != 0);
      bus_if.req1_valid = (q1.size() != 0);
      t = (q0.size() != 0) ? q0[0] : 9'h000;
      bus_if.req0_data = t[7:0];
      bus_if.req0_lock = t[8];
      t = (q1.size() != 0) ? q1[0] : 9'h000;
      bus_if.req1_data = t[7:0];
      bus_if.req1_lock = t[8];
   endtask

   task automatic run_traffic(input int budget);
      int cyc = 0;
      bit done = 1'b0;
      bit p0, p1;
      while (!done && cyc < budget) begin
         drive_reqs();
         @(negedge clk);
         p0 = bus_if.req0_ready;
         p1 = bus_if.req1_ready;
         if (p0 || p1) begin
            total_cnt++;
            if ((p0 && p1) || bus_if.active)
               $display("FAIL accept_rules: ready0=%0b ready1=%0b active=%0b, required one ready with active=0",
                        p0, p1, bus_if.active);
            else pass_cnt++;
         end
         @(posedge clk); #1;
         if (p0) void'(q0.pop_front());
         if (p1) void'(q1.pop_front());
         cyc++;
         if (q0.size() == 0 && q1.size() == 0 && !bus_if.active && !bus_if.uart_busy && !pend) done = 1'b1;
      end
      drive_reqs();
      total_cnt++;
      if (!done) $display("FAIL traffic_timeout: not drained after %0d cycles", budget);
      else pass_cnt++;
   endtask

   task automatic do_reset();
      int w = 0;
      while ((model_busy || pend) && w < 100) begin @(negedge clk); w++; end
      q0.delete(); q1.delete();
      drive_reqs();
      tx_ack_en = 1'b1; force_busy = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; rst = 1'b0;
      tx_log.delete();
      err_cnt = 0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total_cnt += 8;
      if (bus_if.uart_start !== 1'b0) $display("FAIL reset_uart_start: got %b required 0", bus_if.uart_start); else pass_cnt++;
      if (bus_if.uart_data !== 8'h00) $display("FAIL reset_uart_data: got %h required 00", bus_if.uart_data); else pass_cnt++;
      if (bus_if.grant_id !== 1'b0) $display("FAIL reset_grant_id: got %b required 0", bus_if.grant_id); else pass_cnt++;
      if (bus_if.active !== 1'b0) $display("FAIL reset_active: got %b required 0", bus_if.active); else pass_cnt++;
      if (bus_if.locked !== 1'b0) $display("FAIL reset_locked: got %b required 0", bus_if.locked); else pass_cnt++;
      if (bus_if.err_pulse !== 1'b0) $display("FAIL reset_err_pulse: got %b required 0", bus_if.err_pulse); else pass_cnt++;
      if (bus_if.req0_ready !== 1'b0) $display("FAIL reset_req0_ready: got %b required 0", bus_if.req0_ready); else pass_cnt++;
      if (bus_if.req1_ready !== 1'b0) $display("FAIL reset_req1_ready: got %b required 0", bus_if.req1_ready); else pass_cnt++;
   endtask

   task automatic test_single_byte();
      int n = 0;
      bit seen_busy = 1'b0;
      do_reset();
      bus_if.req0_valid = 1'b1; bus_if.req0_data = 8'h55; bus_if.req0_lock = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (bus_if.req0_ready !== 1'b1) $display("FAIL single_ready: got %b required 1 in the valid cycle", bus_if.req0_ready); else pass_cnt++;
      @(posedge clk); #1;
      bus_if.req0_valid = 1'b0; bus_if.req0_data = 8'h00;
      @(negedge clk);
      total_cnt += 4;
      if (bus_if.uart_start !== 1'b1) $display("FAIL single_start: got %b required 1", bus_if.uart_start); else pass_cnt++;
      if (bus_if.uart_data !== 8'h55) $display("FAIL single_data: got %h required 55", bus_if.uart_data); else pass_cnt++;
      if (bus_if.grant_id !== 1'b0) $display("FAIL single_grant_id: got %b required 0", bus_if.grant_id); else pass_cnt++;
      if (bus_if.active !== 1'b1) $display("FAIL single_active: got %b required 1", bus_if.active); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus_if.uart_start !== 1'b0) $display("FAIL single_start_width: got %b required 0", bus_if.uart_start); else pass_cnt++;
      while (n < 40 && !(seen_busy && !bus_if.uart_busy)) begin
         if (bus_if.uart_busy) seen_busy = 1'b1;
         @(negedge clk); n++;
      end
      total_cnt += 3;
      if (!seen_busy || n >= 40) $display("FAIL single_busy_cycle: busy never rose and fell within %0d cycles", n); else pass_cnt++;
      if (bus_if.active !== 1'b1) $display("FAIL single_active_busy_fall: got %b required 1", bus_if.active); else pass_cnt++;
      @(negedge clk);
      if (bus_if.active !== 1'b0) $display("FAIL single_active_drop: got %b required 0", bus_if.active); else pass_cnt++;
   endtask

   task automatic test_contention();
      bit [8:0] want[4];
      bit [8:0] got;
      do_reset();
      q0 = '{9'h0A0, 9'h0A1};
      q1 = '{9'h0B0, 9'h0B1};
      want = '{9'h0A0, 9'h1B0, 9'h0A1, 9'h1B1};
      run_traffic(300);
      total_cnt++;
      if (tx_log.size() != 4) $display("FAIL contention_count: got %0d required 4", tx_log.size()); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         got = (i < tx_log.size()) ? tx_log[i] : 9'h1FF;
         total_cnt++;
         if (got !== want[i]) $display("FAIL contention_order[%0d]: got id/data %h required %h", i, got, want[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_lock();
      bit [8:0] got;
      do_reset();
      q0.delete(); q1.delete();
      for (int i = 0; i < 2; i++) q0.push_back({1'b0, 8'($urandom_range(0, 255))});
      for (int i = 0; i < 3; i++) q1.push_back({1'b1, 8'($urandom_range(0, 255))});
      src0 = q0; src1 = q1;
      build_expected();
      run_traffic(400);
      total_cnt++;
      if (tx_log.size() != exp_q.size()) $display("FAIL lock_count: got %0d required %0d", tx_log.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < tx_log.size()) ? tx_log[i] : 9'h1FF;
         total_cnt++;
         if (got !== exp_q[i]) $display("FAIL lock_order[%0d]: got id/data %h required %h", i, got, exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_random_traffic();
      bit [8:0] got;
      for (int r = 0; r < 4; r++) begin
         do_reset();
         q0.delete(); q1.delete();
         for (int i = 0; i < int'($urandom_range(1, 6)); i++)
            q0.push_back({($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255))});
         for (int i = 0; i < int'($urandom_range(1, 6)); i++)
            q1.push_back({($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255))});
         src0 = q0; src1 = q1;
         build_expected();
         run_traffic(800);
         total_cnt += 2;
         if (tx_log.size() != exp_q.size()) $display("FAIL random_count[%0d]: got %0d required %0d", r, tx_log.size(), exp_q.size()); else pass_cnt++;
         if (err_cnt != 0) $display("FAIL random_err[%0d]: got %0d err pulses required 0", r, err_cnt); else pass_cnt++;
         for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < tx_log.size()) ? tx_log[i] : 9'h1FF;
            total_cnt++;
            if (got !== exp_q[i]) $display("FAIL random_order[%0d][%0d]: got id/data %h required %h", r, i, got, exp_q[i]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_lock_timeout();
      int n = 0;
      bit prev_locked;
      do_reset();
      bus_if.req0_valid = 1'b1; bus_if.req0_data = 8'h11; bus_if.req0_lock = 1'b1;
      bus_if.req1_valid = 1'b1; bus_if.req1_data = 8'h22; bus_if.req1_lock = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (bus_if.req0_ready !== 1'b1) $display("FAIL ltmo_first_grant: req0_ready got %b required 1", bus_if.req0_ready); else pass_cnt++;
      @(posedge clk); #1;
      bus_if.req0_valid = 1'b0;
      @(negedge clk);
      while (bus_if.active && n < 60) begin @(negedge clk); n++; end
      total_cnt += 2;
      if (bus_if.active) $display("FAIL ltmo_frame_timeout: still active after %0d cycles", n); else pass_cnt++;
      if (bus_if.locked !== 1'b1) $display("FAIL ltmo_locked_idle: got %b required 1", bus_if.locked); else pass_cnt++;
      n = 0;
      prev_locked = bus_if.locked;
      while (!bus_if.req1_ready && n < LT + 20) begin
         prev_locked = bus_if.locked;
         @(negedge clk); n++;
      end
      total_cnt += 3;
      if (n != LT) $display("FAIL ltmo_delay: req1 granted after %0d cycles required %0d", n, LT); else pass_cnt++;
      if (bus_if.locked !== 1'b0) $display("FAIL ltmo_locked_fall: got %b required 0", bus_if.locked); else pass_cnt++;
      if (prev_locked !== 1'b1) $display("FAIL ltmo_locked_before: got %b required 1", prev_locked); else pass_cnt++;
      @(posedge clk); #1;
      bus_if.req1_valid = 1'b0; bus_if.req0_lock = 1'b0;
   endtask

   task automatic test_ack_timeout();
      int m = 0;
      do_reset();
      tx_ack_en = 1'b0; force_busy = 1'b0;
      bus_if.req0_valid = 1'b1; bus_if.req0_data = 8'h3C; bus_if.req0_lock = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (bus_if.req0_ready !== 1'b1) $display("FAIL ack_ready: got %b required 1", bus_if.req0_ready); else pass_cnt++;
      @(posedge clk); #1;
      bus_if.req0_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (bus_if.uart_start !== 1'b1 || bus_if.uart_data !== 8'h3C)
         $display("FAIL ack_start: start=%b data=%h required 1/3c", bus_if.uart_start, bus_if.uart_data);
      else pass_cnt++;
      while (!bus_if.err_pulse && m < 20) begin @(negedge clk); m++; end
      total_cnt += 3;
      if (m != AT + 1) $display("FAIL ack_err_delay: err after %0d cycles from start required %0d", m, AT + 1); else pass_cnt++;
      if (bus_if.active !== 1'b0) $display("FAIL ack_idle: active got %b required 0", bus_if.active); else pass_cnt++;
      if (bus_if.locked !== 1'b1) $display("FAIL ack_lock_kept: got %b required 1", bus_if.locked); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus_if.err_pulse !== 1'b0) $display("FAIL ack_err_width: got %b required 0", bus_if.err_pulse); else pass_cnt++;
      @(posedge clk); #1;
      tx_ack_en = 1'b1;
      tx_log.delete(); err_cnt = 0;
      q0.delete(); q1.delete();
      q0.push_back(9'h0A5);
      run_traffic(200);
      total_cnt += 2;
      if (tx_log.size() != 1 || tx_log[0] !== 9'h0A5)
         $display("FAIL ack_next_byte: got %0d bytes first %h required 1 byte 0a5", tx_log.size(), (tx_log.size() != 0) ? tx_log[0] : 9'h1FF);
      else pass_cnt++;
      if (err_cnt != 0) $display("FAIL ack_next_err: got %0d required 0", err_cnt); else pass_cnt++;
   endtask

   task automatic test_busy_idle();
      int seen = 0;
      do_reset();
      tx_ack_en = 1'b0; force_busy = 1'b1;
      bus_if.req1_valid = 1'b1; bus_if.req1_data = 8'($urandom_range(0, 255)); bus_if.req1_lock = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus_if.req0_ready || bus_if.req1_ready) seen++;
      end
      total_cnt++;
      if (seen != 0) $display("FAIL busy_idle_hold: got %0d ready cycles required 0", seen); else pass_cnt++;
      @(posedge clk); #1;
      force_busy = 1'b0; tx_ack_en = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (bus_if.req1_ready !== 1'b1) $display("FAIL busy_idle_release: req1_ready got %b required 1", bus_if.req1_ready); else pass_cnt++;
      @(posedge clk); #1;
      bus_if.req1_valid = 1'b0;
   endtask

   task automatic test_reset_midframe();
      int n = 0;
      do_reset();
      bus_if.req1_valid = 1'b1; bus_if.req1_data = 8'h77; bus_if.req1_lock = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      bus_if.req1_valid = 1'b0; bus_if.req1_lock = 1'b0;
      while (!bus_if.uart_busy && n < 20) begin @(negedge clk); n++; end
      @(negedge clk); @(negedge clk);
      total_cnt++;
      if (!(bus_if.uart_busy && bus_if.active && bus_if.locked && bus_if.grant_id))
         $display("FAIL midframe_setup: busy=%b active=%b locked=%b gid=%b required all 1",
                  bus_if.uart_busy, bus_if.active, bus_if.locked, bus_if.grant_id);
      else pass_cnt++;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      total_cnt += 6;
      if (bus_if.active !== 1'b0) $display("FAIL midframe_active: got %b required 0", bus_if.active); else pass_cnt++;
      if (bus_if.uart_start !== 1'b0) $display("FAIL midframe_start: got %b required 0", bus_if.uart_start); else pass_cnt++;
      if (bus_if.uart_data !== 8'h00) $display("FAIL midframe_data: got %h required 00", bus_if.uart_data); else pass_cnt++;
      if (bus_if.grant_id !== 1'b0) $display("FAIL midframe_grant_id: got %b required 0", bus_if.grant_id); else pass_cnt++;
      if (bus_if.locked !== 1'b0) $display("FAIL midframe_locked: got %b required 0", bus_if.locked); else pass_cnt++;
      if (bus_if.err_pulse !== 1'b0) $display("FAIL midframe_err: got %b required 0", bus_if.err_pulse); else pass_cnt++;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_if.uart_start) n++;
      end
      total_cnt++;
      if (n != 0) $display("FAIL midframe_no_retry: got %0d start pulses required 0", n); else pass_cnt++;
   endtask

   initial begin
      q0.delete(); q1.delete();
      drive_reqs();
      test_reset();
      test_single_byte();
      test_contention();
      test_lock();
      test_random_traffic();
      test_lock_timeout();
      test_ack_timeout();
      test_busy_idle();
      test_reset_midframe();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
      $fatal(1);
   end
endmodule
